// File: rtl/cache_axi_bridge_pkg.sv
// rtl/cache_axi_bridge_pkg.sv - shared cache/AXI bridge definitions
package cache_axi_bridge_pkg;

  localparam int         LINE_BEATS     = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_BEATS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} rd_state_t;

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} wr_state_t;

endpackage

// File: rtl/cache_axi_wr_engine.sv
// rtl/cache_axi_wr_engine.sv - cache line write-back engine (AW, W, B channels)
module cache_axi_wr_engine
  import cache_axi_bridge_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int WR_ID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_req,
  input  logic [27:0]     wr_line,
  input  logic [127:0]    wr_data,
  output logic            wr_rdy,
  output logic            wr_valid,
  output logic            busy,
  output logic [27:0]     line,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic            bvalid,
  output logic            bready
);

  wr_state_t    state, state_nx;
  logic [27:0]  line_q;
  logic [127:0] data_q;
  logic [1:0]   beat;
  logic         aw_done, w_done;
  logic         aw_hs, w_hs, last_hs;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign last_hs = w_hs && wlast;

  // State register, latched victim line, W beat counter and channel done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= W_IDLE;
      line_q  <= '0;
      data_q  <= '0;
      beat    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr_req && wr_rdy) begin
        line_q  <= wr_line;
        data_q  <= wr_data;
        beat    <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs)   aw_done <= 1'b1;
        if (w_hs)    beat    <= beat + 2'd1;
        if (last_hs) w_done  <= 1'b1;
      end
    end
  end

  // Next state and handshake outputs; AW and W run concurrently, the state
  // only records whether the address has gone out yet
  always_comb begin
    state_nx = state;
    wr_rdy   = 1'b0;
    wr_valid = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    case (state)
      W_IDLE: begin
        wr_rdy = !rst;
        if (wr_req && wr_rdy) state_nx = W_ADDR;
      end
      W_ADDR: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if (aw_hs) state_nx = (w_done || last_hs) ? W_RESP : W_DATA;
      end
      W_DATA: begin
        wvalid = !w_done;
        if (w_done || last_hs) state_nx = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nx = W_DONE;
      end
      W_DONE: begin
        wr_valid = 1'b1;
        state_nx = W_IDLE;
      end
      default: state_nx = W_IDLE;
    endcase
  end

  assign awid    = ID_W'(WR_ID);
  assign awaddr  = {line_q, 4'b0000};
  assign awlen   = AXI_LEN_LINE;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = data_q[{beat, 5'd0} +: 32];
  assign wstrb   = 4'hF;
  assign wlast   = wvalid && (beat == 2'd3);
  assign busy    = (state != W_IDLE);
  assign line    = line_q;

endmodule

// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - cache line fill / write-back bridge to AXI
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int RD_ID = 0,
  parameter int WR_ID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req,
  input  logic [31:0]     rd_addr,
  output logic            rd_rdy,
  output logic            ret_valid,
  output logic [127:0]    ret_data,
  input  logic            wr_req,
  input  logic [31:0]     wr_addr,
  input  logic [127:0]    wr_data,
  output logic            wr_rdy,
  output logic            wr_valid,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  rd_state_t    r_state, r_state_nx;
  logic [27:0]  r_line;
  logic [1:0]   r_beat;
  logic [127:0] r_buf;
  logic         wr_busy;
  logic [27:0]  wr_line_q;
  logic         hazard;
  logic         unused_ok;

  // Response IDs/status are deliberately ignored; low address bits select
  // nothing since transfers are always whole lines
  assign unused_ok = ^{rid, rresp, bid, bresp, rd_addr[3:0], wr_addr[3:0]};

  // A fill of the line currently being written back would return stale data
  assign hazard = wr_busy && (rd_addr[31:4] == wr_line_q);

  // Read state register, latched line address, beat counter and line buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_line  <= '0;
      r_beat  <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= r_state_nx;
      if (rd_req && rd_rdy) begin
        r_line <= rd_addr[31:4];
        r_beat <= '0;
      end else if (r_state == R_DATA && rvalid) begin
        r_buf[{r_beat, 5'd0} +: 32] <= rdata;
        r_beat <= rlast ? 2'd0 : r_beat + 2'd1;
      end
    end
  end

  // Read next state and handshake outputs
  always_comb begin
    r_state_nx = r_state;
    rd_rdy     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    ret_valid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        rd_rdy = !rst && !hazard;
        if (rd_req && rd_rdy) r_state_nx = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_state_nx = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) r_state_nx = R_RET;
      end
      R_RET: begin
        ret_valid  = 1'b1;
        r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  assign arid     = ID_W'(RD_ID);
  assign araddr   = {r_line, 4'b0000};
  assign arlen    = AXI_LEN_LINE;
  assign arsize   = AXI_SIZE_WORD;
  assign arburst  = AXI_BURST_INCR;
  assign ret_data = r_buf;

  cache_axi_wr_engine #(
    .ID_W  (ID_W),
    .WR_ID (WR_ID)
  ) u_wr (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_line  (wr_addr[31:4]),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .wr_valid (wr_valid),
    .busy     (wr_busy),
    .line     (wr_line_q),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .bready   (bready)
  );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - directed self-checking bench for cache_axi_bridge
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         wr_valid;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0]      addr;
    logic [0:3][31:0] beats;
    logic [31:0]      exp_araddr;
    logic [127:0]     exp_data;
    int               ar_delay;
  } rd_vec_t;

  typedef struct {
    logic [31:0]      addr;
    logic [127:0]     data;
    logic [31:0]      exp_awaddr;
    logic [0:3][31:0] exp_words;
    int               aw_delay;
    int               w_stall;
  } wr_vec_t;

  rd_vec_t rv[4];
  wr_vec_t wv[4];

  cache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_accept(input logic [31:0] addr);
    rd_addr = addr;
    #1;
    chk("rd_rdy_accept", rd_rdy, 1'b1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic rd_finish(input logic [31:0] exp_araddr, input logic [0:3][31:0] beats,
                           input int ar_delay, input logic [127:0] exp_data);
    chk("arvalid_latency", arvalid, 1'b1);
    chk("araddr", araddr, exp_araddr);
    chk("arlen", arlen, 8'd3);
    chk("arsize", arsize, 3'd2);
    chk("arburst", arburst, 2'b01);
    chk("arid", arid, 4'd0);
    for (int i = 0; i < ar_delay; i++) begin
      arready = 1'b0;
      tick();
      chk("arvalid_hold", arvalid, 1'b1);
      chk("araddr_stable", araddr, exp_araddr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("arvalid_drop", arvalid, 1'b0);
    chk("rready", rready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1;
      rdata  = beats[k];
      rlast  = (k == 3);
      rid    = 4'(k + 5);
      rresp  = 2'(k);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("ret_valid_pulse", ret_valid, 1'b1);
    chk("ret_data", ret_data, exp_data);
    tick();
    chk("ret_valid_single", ret_valid, 1'b0);
    chk("ret_data_hold", ret_data, exp_data);
    chk("rd_rdy_after_ret", rd_rdy, 1'b1);
  endtask

  task automatic wr_accept(input logic [31:0] addr, input logic [127:0] data);
    wr_addr = addr;
    wr_data = data;
    #1;
    chk("wr_rdy_accept", wr_rdy, 1'b1);
    wr_req = 1'b1;
    tick();
    wr_req  = 1'b0;
    wr_data = '0;
    wr_addr = '0;
  endtask

  task automatic wr_finish(input logic [31:0] exp_awaddr, input logic [0:3][31:0] exp_words,
                           input int aw_delay, input int w_stall, input bit chk_hz);
    int   cyc;
    int   beat;
    bit   aw_seen;
    logic hs_aw, hs_w;
    cyc = 0;
    beat = 0;
    aw_seen = 1'b0;
    chk("awvalid_start", awvalid, 1'b1);
    chk("wvalid_start", wvalid, 1'b1);
    while (!(aw_seen && beat == 4) && cyc < 50) begin
      awready = (cyc >= aw_delay);
      wready  = (cyc >= w_stall);
      #1;
      if (awvalid) begin
        if (aw_seen) chk("awvalid_after_hs", awvalid, 1'b0);
        chk("awaddr", awaddr, exp_awaddr);
        chk("awlen", awlen, 8'd3);
        chk("awsize", awsize, 3'd2);
        chk("awburst", awburst, 2'b01);
        chk("awid", awid, 4'd1);
      end
      if (wvalid) begin
        if (beat < 4) begin
          chk("wdata", wdata, exp_words[beat]);
          chk("wlast", wlast, (beat == 3));
          chk("wstrb", wstrb, 4'hF);
        end else begin
          chk("wvalid_extra", wvalid, 1'b0);
        end
      end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) aw_seen = 1'b1;
      if (hs_w)  beat++;
      cyc++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk("w_phase_done", {aw_seen, (beat == 4)}, 2'b11);
    chk("bready", bready, 1'b1);
    chk("wvalid_idle", wvalid, 1'b0);
    if (chk_hz) chk("hz_rd_rdy_resp", rd_rdy, 1'b0);
    bvalid = 1'b1;
    bid    = 4'd1;
    bresp  = 2'b10;
    tick();
    bvalid = 1'b0;
    chk("wr_valid_pulse", wr_valid, 1'b1);
    chk("bready_drop", bready, 1'b0);
    if (chk_hz) chk("hz_rd_rdy_done", rd_rdy, 1'b0);
    tick();
    chk("wr_valid_single", wr_valid, 1'b0);
    chk("wr_rdy_after", wr_rdy, 1'b1);
    if (chk_hz) chk("hz_rd_rdy_release", rd_rdy, 1'b1);
  endtask

  initial begin
    rv[0] = '{32'h1FC0_0014, {32'h11, 32'h22, 32'h33, 32'h44}, 32'h1FC0_0010,
              128'h00000044_00000033_00000022_00000011, 0};
    rv[1] = '{32'h0000_000F, {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF}, 32'h0000_0000,
              128'hFFFFFFFF_89ABCDEF_01234567_DEADBEEF, 1};
    rv[2] = '{32'hFFFF_FFF8, {32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003}, 32'hFFFF_FFF0,
              128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 3};
    rv[3] = '{32'h1234_5678, {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 32'h80000001}, 32'h1234_5670,
              128'h80000001_00000000_5A5A5A5A_A5A5A5A5, 2};

    wv[0] = '{32'h8000_0020, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 32'h8000_0020,
              {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD}, 0, 0};
    wv[1] = '{32'h1000_003C, 128'h44444444_33333333_22222222_11111111, 32'h1000_0030,
              {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 3, 3};
    wv[2] = '{32'hFFFF_FFFF, 128'h0000000F_0000000E_0000000D_0000000C, 32'hFFFF_FFF0,
              {32'h0000000C, 32'h0000000D, 32'h0000000E, 32'h0000000F}, 3, 0};
    wv[3] = '{32'h0000_0005, 128'h01020304_05060708_090A0B0C_0D0E0F10, 32'h0000_0000,
              {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304}, 0, 3};

    rst = 1'b1;
    rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_rd_rdy", rd_rdy, 1'b0);
    chk("rst_wr_rdy", wr_rdy, 1'b0);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid, wr_valid}, 8'h00);
    chk("rst_ret_data", ret_data, 128'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_rd_rdy", rd_rdy, 1'b1);
    chk("post_rst_wr_rdy", wr_rdy, 1'b1);

    // Table-driven fills and write-backs
    for (int i = 0; i < 4; i++) begin
      rd_accept(rv[i].addr);
      rd_finish(rv[i].exp_araddr, rv[i].beats, rv[i].ar_delay, rv[i].exp_data);
    end
    for (int i = 0; i < 4; i++) begin
      wr_accept(wv[i].addr, wv[i].data);
      wr_finish(wv[i].exp_awaddr, wv[i].exp_words, wv[i].aw_delay, wv[i].w_stall, 1'b0);
    end

    // Simultaneous read and write accept
    rd_addr = 32'h0000_2000;
    wr_addr = 32'h0000_3000;
    wr_data = 128'h00000004_00000003_00000002_00000001;
    #1;
    chk("dual_rd_rdy", rd_rdy, 1'b1);
    chk("dual_wr_rdy", wr_rdy, 1'b1);
    rd_req = 1'b1;
    wr_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    wr_data = '0;
    rd_finish(32'h0000_2000, {32'h70, 32'h71, 32'h72, 32'h73}, 0,
              128'h00000073_00000072_00000071_00000070);
    wr_finish(32'h0000_3000, {32'h1, 32'h2, 32'h3, 32'h4}, 0, 0, 1'b0);

    // Read-after-write hazard: same line blocked, other line proceeds
    wr_accept(32'h8000_0020, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    rd_addr = 32'h8000_002C;
    #1;
    chk("hz_block", rd_rdy, 1'b0);
    tick();
    chk("hz_block_hold", rd_rdy, 1'b0);
    rd_accept(32'h8000_0040);
    rd_finish(32'h8000_0040, {32'h40, 32'h41, 32'h42, 32'h43}, 0,
              128'h00000043_00000042_00000041_00000040);
    rd_addr = 32'h8000_002C;
    #1;
    chk("hz_block_again", rd_rdy, 1'b0);
    wr_finish(32'h8000_0020, {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD}, 0, 0, 1'b1);

    // Reset in the middle of a fill after two beats
    rd_accept(32'h0000_1000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hBAD0_0000;
    tick();
    rdata = 32'hBAD0_0001;
    tick();
    rvalid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_valids", {arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid, wr_valid}, 8'h00);
    chk("midrst_rd_rdy", rd_rdy, 1'b0);
    chk("midrst_ret_data", ret_data, 128'h0);
    rst = 1'b0;
    tick();
    chk("midrst_release_rd_rdy", rd_rdy, 1'b1);
    rd_accept(32'h0000_1004);
    rd_finish(32'h0000_1000, {32'h5, 32'h6, 32'h7, 32'h8}, 0,
              128'h00000008_00000007_00000006_00000005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have parameter ID_W, default 4, meaning AXI ID width.
REQ-002 SHALL have parameter RD_ID, default 0, meaning arid value driven on every read burst.
REQ-003 SHALL have parameter WR_ID, default 1, meaning awid value driven on every write burst.
REQ-004 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port rd_req  in  1  cache line-fill request.
REQ-007 SHALL have port rd_addr  in  32  fill address (any byte within the line).
REQ-008 SHALL have port rd_rdy  out  1  bridge can accept rd_req this cycle.
REQ-009 SHALL have port ret_valid  out  1  fill data valid, one-cycle pulse.
REQ-010 SHALL have port ret_data  out  128  filled line, word i in bits [32i+31:32i].
REQ-011 SHALL have port wr_req  in  1  cache write-back request.
REQ-012 SHALL have port wr_addr  in  32  write-back address.
REQ-013 SHALL have port wr_data  in  128  victim line, same word ordering as ret_data.
REQ-014 SHALL have port wr_rdy  out  1  bridge can accept wr_req this cycle.
REQ-015 SHALL have port wr_valid  out  1  write-back completed (B received), one-cycle pulse.
REQ-016 SHALL have AXI AR ports: arid ID_W, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 out; arready 1 in.
REQ-017 SHALL have AXI R ports: rid ID_W, rdata 32, rresp 2, rlast 1, rvalid 1 in; rready 1 out.
REQ-018 SHALL have AXI AW ports: awid ID_W, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1 out; awready 1 in.
REQ-019 SHALL have AXI W ports: wdata 32, wstrb 4, wlast 1, wvalid 1 out; wready 1 in.
REQ-020 SHALL have AXI B ports: bid ID_W, bresp 2, bvalid 1 in; bready 1 out.

Function
REQ-021 SHALL run independent read FSM (R_IDLE, R_AR, R_DATA, R_RET) and write FSM (W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE).
REQ-022 SHALL accept a read when rd_req && rd_rdy; rd_rdy=1 only in R_IDLE and not blocked by REQ-031.
REQ-023 SHALL on read accept latch {rd_addr[31:4],4'b0} and enter R_AR; arvalid=1 held until arready, arlen=3, arsize=2, arburst=2'b01 (INCR), arid=RD_ID.
REQ-024 SHALL in R_DATA drive rready=1, store beat k (0..3, counter) into line buffer word k; on rvalid&&rlast enter R_RET.
REQ-025 SHALL in R_RET assert ret_valid for exactly one cycle with ret_data = buffer, then return to R_IDLE; ret_data holds value until next fill.
REQ-026 SHALL ignore rresp and rid values (data returned regardless); beat counter wraps by rlast, not by count.
REQ-027 SHALL accept a write when wr_req && wr_rdy; wr_rdy=1 only in W_IDLE; latch line-aligned address and full 128-bit data.
REQ-028 SHALL drive awvalid and the W channel concurrently (W_ADDR/W_DATA tracked by separate done flags); awlen=3, awsize=2, awburst=INCR, awid=WR_ID; wstrb=4'hF; wdata = word k; wlast=1 on k=3.
REQ-029 SHALL after both AW handshake and wlast handshake enter W_RESP with bready=1; on bvalid enter W_DONE, pulse wr_valid one cycle, return to W_IDLE.
REQ-030 SHALL accept rd_req and wr_req in the same cycle when both FSMs idle and no conflict.
REQ-031 SHALL deassert rd_rdy while write FSM is not W_IDLE and rd_addr[31:4] equals latched write line address (read-after-write hazard); rd_rdy reasserts the cycle after wr_valid.
REQ-032 SHALL have minimum read latency: accept at cycle 0, arvalid cycle 1, ret_valid one cycle after last R beat.
REQ-033 SHALL hold all AXI payload signals stable while the corresponding valid is high and ready low.

Reset
REQ-034 SHALL on rst force both FSMs to idle, beat counters and done flags to 0, mid-transaction bursts abandoned.
REQ-035 SHALL reset outputs: arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid, wr_valid = 0; rd_rdy = wr_rdy = 0 during rst, 1 first cycle after; ret_data = 0.

Structure
REQ-036 SHALL place read/write state enums, AXI_BURST_INCR, LINE_BEATS=4, AXI_SIZE_WORD=3'd2 in the shared cache defines package.
REQ-037 SHALL implement the write path as one sub-module cache_axi_wr_engine; read path stays in the top.

Verification
REQ-038 SHALL cover read fill: rd_req, rd_addr=0x1FC0_0014 -> araddr=0x1FC0_0010, arlen=3; rdata 0x11,0x22,0x33,0x44 -> ret_data=0x00000044_00000033_00000022_00000011, one-cycle ret_valid.
REQ-039 SHALL cover write-back: wr_addr=0x8000_0020, wr_data=0xDDDD..._AAAA... -> wdata AAAA,BBBB,CCCC,DDDD, wlast on 4th, wr_valid one cycle after bvalid.
REQ-040 SHALL cover backpressure: arready/wready/awready low 3 random cycles -> payloads stable, no lost beats.
REQ-041 SHALL cover hazard: write to 0x8000_0020 pending, rd_req to 0x8000_002C -> rd_rdy=0 until after wr_valid; rd_req to 0x8000_0040 -> accepted immediately.
REQ-042 SHALL cover reset mid-read after 2 beats -> all valids 0 next cycle, rd_rdy=1 after rst release, fresh fill returns correct data.
